// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the EX stage's single-cycle data SRAM request into
// one split-handshake bus transaction (req/addr_ok, then data_ok). It stalls
// the pipeline until the transaction completes and returns load data to MEM.
// Optional feature macro: DATA_BRIDGE_PERF_CNT_EN (performance counters).
module data_sram_bridge #(
    parameter int unsigned KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_for_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned WENW = 4;
    localparam int unsigned SZW  = 2;

    localparam logic [SZW-1:0] SIZE_BYTE = SZW'(0);
    localparam logic [SZW-1:0] SIZE_HALF = SZW'(1);
    localparam logic [SZW-1:0] SIZE_WORD = SZW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_cancel;
    logic             r_wr;
    logic [SZW-1:0]   r_size;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;

    logic             w_latch;
    logic             w_complete;
    logic             w_set_cancel;
    logic             w_cancel_eff;
    logic             w_load_rdata;
    logic             w_stall;
    logic             w_req;
    logic             w_is_store;
    logic [SZW-1:0]   w_size;
    logic [AW-1:0]    w_addr_pre;
    logic [AW-1:0]    w_addr_map;

    // A flush arriving together with the completion still kills the load.
    assign w_cancel_eff = r_cancel | flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, handshake and stall decode.
    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_complete   = 1'b0;
        w_set_cancel = 1'b0;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_sram_en && !flush) begin
                    w_latch = 1'b1;
                    w_stall = 1'b1;
                    w_next  = S_REQ;
                end
            end
            S_REQ: begin
                w_req        = 1'b1;
                w_stall      = 1'b1;
                w_set_cancel = flush;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_complete = 1'b1;
                        w_next     = w_cancel_eff ? S_IDLE : S_DONE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall      = 1'b1;
                w_set_cancel = flush;
                if (data_data_ok) begin
                    w_complete = 1'b1;
                    w_next     = w_cancel_eff ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                // EX still presents the finished request here; ignore it.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_load_rdata     = w_complete & ~w_cancel_eff & ~r_wr;
    assign stallreq_for_mem = w_stall;
    assign data_req         = w_req;

    // Transfer size from byte enables; loads always fetch a full word.
    assign w_is_store = |data_sram_wen;
    always_comb begin
        w_size = SIZE_WORD;
        if (w_is_store) begin
            case (data_sram_wen)
                4'b1111:                            w_size = SIZE_WORD;
                4'b0011, 4'b1100:                   w_size = SIZE_HALF;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = SIZE_BYTE;
                default:                            w_size = SIZE_WORD;
            endcase
        end
    end

    // Word-align loads, then fold kseg0/kseg1 onto physical space if enabled.
    assign w_addr_pre = w_is_store ? data_sram_addr
                                   : {data_sram_addr[AW-1:2], 2'b00};
    assign w_addr_map = ((KSEG_MAP != 32'd0) && (w_addr_pre[AW-1:AW-2] == 2'b10))
                        ? {3'b000, w_addr_pre[AW-4:0]}
                        : w_addr_pre;

    // Command latch, held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_wr    <= w_is_store;
            r_size  <= w_size;
            r_addr  <= w_addr_map;
            r_wdata <= data_sram_wdata;
        end
    end

    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;

    // Cancel flag: marks the in-flight transaction as belonging to a flushed instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cancel <= 1'b0;
        end else if (w_latch) begin
            r_cancel <= 1'b0;
        end else if (w_set_cancel) begin
            r_cancel <= 1'b1;
        end
    end

    // Load return register, visible to MEM from the DONE cycle onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_load_rdata) begin
            r_rdata <= data_rdata;
        end
    end

    assign data_sram_rdata = r_rdata;

`ifdef DATA_BRIDGE_PERF_CNT_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_stall;

    // Completed-transaction and stall-cycle counters (free-running, wrapping).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_req   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_complete) begin
                r_perf_req <= r_perf_req + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_req_cnt   = r_perf_req;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_req_cnt   = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: directed transactions, scoreboard queues
// for bus commands and for end-of-stall results, checked by a monitor.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_for_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;

    data_sram_bridge #(.KSEG_MAP(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_mem (stallreq_for_mem),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_rdata       (data_rdata),
        .data_data_ok     (data_data_ok),
        .perf_req_cnt     (perf_req_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] len;
        logic [31:0] rdata;
    } end_t;

    cmd_t        q_cmd[$];
    end_t        q_end[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bus commands at addr_ok, stall length and rdata when stall drops.
    logic [31:0] run_len = 32'd0;
    logic        prev_stall = 1'b0;
    cmd_t        e_cmd;
    end_t        e_end;
    always @(negedge clk) begin
        if (data_req && q_cmd.size() == 0) begin
            chk("unexpected_req", data_addr, 32'hFFFF_FFFF);
        end else if (data_req && data_addr_ok) begin
            e_cmd = q_cmd.pop_front();
            n_cmp++;
            if ({data_wr, data_size, data_addr, data_wdata} !== e_cmd) begin
                n_err++;
                $display("FAIL bus_cmd: got wr=%b size=%0d addr=%h wdata=%h expected wr=%b size=%0d addr=%h wdata=%h",
                         data_wr, data_size, data_addr, data_wdata,
                         e_cmd.wr, e_cmd.size, e_cmd.addr, e_cmd.wdata);
            end
        end
        if (stallreq_for_mem) begin
            run_len = run_len + 32'd1;
        end else if (prev_stall) begin
            if (q_end.size() == 0) begin
                chk("unexpected_stall_len", run_len, 32'd0);
            end else begin
                e_end = q_end.pop_front();
                chk("stall_len", run_len, e_end.len);
                chk("rdata_at_end", data_sram_rdata, e_end.rdata);
            end
            run_len = 32'd0;
        end
        prev_stall = stallreq_for_mem;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: addr_ok in cycle aok, data_ok in cycle dok, optional flush in cycle fl.
    task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input int aok, input int dok, input int fl, input logic [31:0] bus_rd,
                       input logic [31:0] exp_addr, input logic [1:0] exp_size, input bit idle_after);
        bit   cancelled;
        cmd_t c;
        end_t en;
        cancelled = (fl >= 1) && (fl <= dok);
        c.wr = |wen; c.size = exp_size; c.addr = exp_addr; c.wdata = wdata;
        q_cmd.push_back(c);
        if (wen == 4'b0000 && !cancelled) m_rdata = bus_rd;
        en.len = 32'(dok + 1); en.rdata = m_rdata;
        q_end.push_back(en);
        data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
        for (int k = 0; k <= dok; k++) begin
            data_sram_en = !(cancelled && k > fl);
            flush        = (k == fl);
            data_addr_ok = (k == aok);
            data_data_ok = (k == dok);
            data_rdata   = (k == dok) ? bus_rd : 32'h0BAD_0BAD;
            step();
        end
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0BAD_0BAD;
        if (cancelled) begin
            data_sram_en = 1'b0;
            step();
        end else begin
            step();
            if (idle_after) begin
                data_sram_en = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        cmd_t c;
        end_t en;
        rst = 1'b1; flush = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'd0;
        data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'd0, stallreq_for_mem}, 32'd0);
        chk("reset_req", {31'd0, data_req}, 32'd0);
        chk("reset_rdata", data_sram_rdata, 32'd0);
        chk("reset_addr", data_addr, 32'd0);
        chk("reset_perf", perf_req_cnt | perf_stall_cnt, 32'd0);
        step();

        // Load through kseg mapping, addr_ok at +2, data_ok at +4.
        txn(4'b0000, 32'h8000_1006, 32'd0, 2, 4, -1, 32'hDEAD_BEEF, 32'h0000_1004, 2'd2, 1'b1);
        // Stores: size from byte enables, rdata untouched.
        txn(4'b0100, 32'hA000_0102, 32'h4444_4444, 1, 2, -1, 32'h5555_5555, 32'h0000_0102, 2'd0, 1'b1);
        txn(4'b1100, 32'hA000_0102, 32'h3344_3344, 1, 2, -1, 32'h5555_5555, 32'h0000_0102, 2'd1, 1'b1);
        txn(4'b1111, 32'hA000_0102, 32'h1122_3344, 1, 2, -1, 32'h5555_5555, 32'h0000_0102, 2'd2, 1'b1);
        txn(4'b0001, 32'h8000_0003, 32'h7777_7777, 2, 3, -1, 32'h5555_5555, 32'h0000_0003, 2'd0, 1'b1);
        txn(4'b0110, 32'hA000_0102, 32'h0066_6600, 1, 2, -1, 32'h5555_5555, 32'h0000_0102, 2'd2, 1'b1);
        // addr_ok and data_ok together in the first REQ cycle; unmapped address.
        txn(4'b0000, 32'h0000_2000, 32'd0, 1, 1, -1, 32'h1234_5678, 32'h0000_2000, 2'd2, 1'b1);
        // Flushed load: completes on the bus but rdata keeps its old value.
        txn(4'b0000, 32'h9000_0010, 32'd0, 3, 5, 1, 32'hCAFE_F00D, 32'h1000_0010, 2'd2, 1'b1);
        // Back-to-back loads.
        txn(4'b0000, 32'h0000_3000, 32'd0, 1, 2, -1, 32'hAAAA_0001, 32'h0000_3000, 2'd2, 1'b0);
        txn(4'b0000, 32'h0000_3004, 32'd0, 1, 3, -1, 32'hBBBB_0002, 32'h0000_3004, 2'd2, 1'b1);

        // Reset while in WAIT, then a stray data_ok.
        c.wr = 1'b0; c.size = 2'd2; c.addr = 32'h0000_4000; c.wdata = 32'd0;
        q_cmd.push_back(c);
        m_rdata = 32'd0;
        en.len = 32'd4; en.rdata = 32'd0;
        q_end.push_back(en);
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_4000; data_sram_wdata = 32'd0;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        step();
        rst = 1'b1; data_sram_en = 1'b0;
        step();
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("rst_wait_stall", {31'd0, stallreq_for_mem}, 32'd0);
        chk("rst_wait_req", {31'd0, data_req}, 32'd0);
        chk("rst_wait_cmd", {29'd0, data_wr, data_size} | data_addr | data_wdata, 32'd0);
        chk("rst_wait_rdata", data_sram_rdata, 32'd0);
        chk("rst_wait_perf", perf_req_cnt | perf_stall_cnt, 32'd0);
        step();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("stray_ok_req", {31'd0, data_req}, 32'd0);
        chk("stray_ok_stall", {31'd0, stallreq_for_mem}, 32'd0);
        chk("stray_ok_rdata", data_sram_rdata, 32'd0);
        step();

        // Post-reset load, then counter check.
        txn(4'b0000, 32'h8000_0020, 32'd0, 1, 2, -1, 32'h0F0F_0F0F, 32'h0000_0020, 2'd2, 1'b1);
`ifdef DATA_BRIDGE_PERF_CNT_EN
        chk("perf_req", perf_req_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd3);
`else
        chk("perf_tied", perf_req_cnt | perf_stall_cnt, 32'd0);
`endif
        repeat (3) step();
        chk("queues_drained", 32'(q_cmd.size() + q_end.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Memory-side responder for the EX stage's single-cycle data SRAM request port (data_sram_en/wen/addr/wdata).
- Converts each request into one transaction on a split-handshake data bus (req/addr_ok, then data_ok).
- Stalls the pipeline until the transaction completes, and returns load data to the MEM stage.
- Sits between the EX/MEM stages and the bus/AXI adapter.

Parameters:
- KSEG_MAP, 1, when 1, any address in 0x8000_0000–0xBFFF_FFFF has bits [31:29] cleared before issue; when 0, addresses pass through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush pulse
- data_sram_en  in  1  request valid from EX
- data_sram_wen  in  4  byte write enables; 0 = load
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data, already lane-replicated by EX
- data_sram_rdata  out  32  last completed load word
- stallreq_for_mem  out  1  stall request to the pipeline controller
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  address accepted
- data_rdata  in  32  bus read data
- data_data_ok  in  1  data phase complete
- perf_req_cnt  out  32  completed transactions (optional feature)
- perf_stall_cnt  out  32  stall cycles (optional feature)

Behaviour:
- Reset (rst=1 at a clock edge): state to IDLE; cancel flag cleared. All outputs are 0, including data_sram_rdata and the perf counters. Any data_ok arriving in the first cycle after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - data_sram_en=1 and flush=0: latch the command, go to REQ.
  - stallreq_for_mem is combinationally 1 in this same cycle.
  - data_sram_en=1 with flush=1: no latch, stay in IDLE, stall stays 0.
- REQ:
  - data_req=1 and the command fields are held stable.
  - On data_addr_ok: go to WAIT.
  - data_addr_ok and data_data_ok in the same cycle: go directly to DONE (or IDLE if cancelled).
  - data_req is never retracted before data_addr_ok.
- WAIT: data_req=0; on data_data_ok go to DONE, or go to IDLE if the cancel flag is set.
- DONE:
  - stallreq_for_mem=0; data_sram_en is ignored because EX still shows the finished request.
  - Always go to IDLE next cycle.
- stallreq_for_mem equals (IDLE & data_sram_en & ~flush) | REQ | WAIT.
- Command latch:
  - data_wr = |wen.
  - data_wdata = data_sram_wdata.
  - Load: data_size=2 and data_addr={addr[31:2],2'b00}.
  - Store: size from wen. 1111 → 2; 0011 or 1100 → 1; one-hot → 0; any other pattern → 2.
  - Store address is addr unchanged; KSEG_MAP is applied after the above.
- data_sram_rdata:
  - Loaded from data_rdata on data_ok of a non-cancelled load.
  - Held otherwise; stores never change it.
  - Becomes valid in DONE, i.e. the cycle the load instruction enters MEM.
- Flush:
  - Flush during REQ or WAIT sets the cancel flag. The transaction still completes on the bus and stall stays 1 until data_ok.
  - A cancelled completion goes to IDLE and updates neither rdata nor DONE.
  - Flush in DONE has no effect.
- Only one transaction is outstanding at a time. data_ok is not accepted in IDLE or REQ unless addr_ok is also present in REQ.

Optional Feature:
- Macro DATA_BRIDGE_PERF_CNT_EN.
- Defined:
  - perf_req_cnt increments on every data_ok, including cancelled ones.
  - perf_stall_cnt increments on each cycle stallreq_for_mem=1.
  - Both are 32-bit, wrap at 0xFFFF_FFFF→0, and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load, en=1, wen=0, addr=0x8000_1006; addr_ok at cycle+2, data_ok with 0xDEADBEEF at cycle+4:
  - data_addr=0x0000_1004, size=2, wr=0.
  - Stall is 1 for 5 cycles.
  - rdata=0xDEADBEEF in DONE.
- Stores wen=0100 / 1100 / 1111 at addr 0xA000_0102 → size 0 / 1 / 2, data_addr=0x0000_0102, wr=1; data_sram_rdata unchanged.
- addr_ok and data_ok in the same cycle as the first req cycle → REQ→DONE; stall is 1 for exactly 2 cycles.
- Flush one cycle after the load request → req held to addr_ok; rdata keeps its old value; no DONE cycle; stall drops when data_ok is seen.
- Back-to-back loads (new en in the cycle after DONE) → two distinct transactions; no duplicate request during DONE.
- rst asserted while in WAIT → IDLE with all outputs 0 next cycle; a following data_ok is ignored. With the macro defined, the counters read 0.
